chunked_ripple_adder: RTL

CHUNKED_RIPPLE_ADDER -- requirements
Module: chunked_ripple_adder

---
 rtl/chunked_ripple_adder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per cycle through a registered carry; DONE NCHUNK+1 cycles after START, which is ignored while busy.
// Optional macro ADDER_SUB_EN adds the SUB port and A-B mode (B inverted, carry seeded with 1).
module chunked_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sub_req;
  logic             last_chunk;
  int unsigned      chunk_base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_out;
  logic             carry_into_msb;

`ifdef ADDER_SUB_EN
  assign sub_req = SUB;
`else
  assign sub_req = 1'b0;
`endif

  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // B is stored already inverted for subtract, so the datapath is a plain adder
  always_comb begin
    chunk_base = 32'(k_q) * 32'(CHUNK);
    a_chunk    = a_q[chunk_base +: CHUNK];
    b_chunk    = b_q[chunk_base +: CHUNK];
    {carry_out, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    carry_into_msb = sum_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = sub_req ? ~B : B;
          carry_d = sub_req ? 1'b1 : CIN;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[chunk_base +: CHUNK] = sum_chunk;
        carry_d = carry_out;
        if (last_chunk) begin
          cout_d  = carry_out;
          ovf_d   = carry_into_msb ^ carry_out;
          state_d = ST_FIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_FIN);

endmodule
